// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and a counter-width helper.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Number of bits needed to count 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide engine. One shift/add-subtract
// step per cycle over a shared 2*WIDTH accumulator; signs are stripped on
// entry and re-applied in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = clog2(WIDTH);

    md_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_opa;
    logic [WIDTH:0]   w_opb;
    logic             w_sub;
    logic [WIDTH:0]   w_res;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shared WIDTH+1-bit adder/subtractor and the next accumulator value for one step.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        w_sub = 1'b0;
        if (r_is_div) begin
            // Restoring division: shift in the next dividend bit, trial-subtract divisor.
            w_opa = {r_acc_hi, r_acc_lo[WIDTH-1]};
            w_opb = {1'b0, r_opnd};
            w_sub = 1'b1;
        end else begin
            // Shift-add: add multiplicand when the current multiplier bit is set.
            w_opa = {1'b0, r_acc_hi};
            w_opb = r_acc_lo[0] ? {1'b0, r_opnd} : '0;
        end
        w_res = w_sub ? (w_opa - w_opb) : (w_opa + w_opb);

        w_nxt_hi = '0;
        w_nxt_lo = '0;
        if (r_is_div) begin
            // Remainder stays below the divisor, so a negative trial result
            // is visible in the top bit and the partial remainder fits WIDTH bits.
            w_nxt_hi = w_res[WIDTH] ? w_opa[WIDTH-1:0] : w_res[WIDTH-1:0];
            w_nxt_lo = {r_acc_lo[WIDTH-2:0], ~w_res[WIDTH]};
        end else begin
            w_nxt_hi = w_res[WIDTH:1];
            w_nxt_lo = {w_res[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // Sign restoration applied in FIX.
    always_comb begin
        w_prod   = {r_acc_hi, r_acc_lo};
        w_fix_hi = '0;
        w_fix_lo = '0;
        if (r_is_div) begin
            w_fix_lo = r_neg_res ? (~r_acc_lo + 1'b1) : r_acc_lo;
            w_fix_hi = r_neg_rem ? (~r_acc_hi + 1'b1) : r_acc_hi;
        end else if (r_neg_res) begin
            {w_fix_hi, w_fix_lo} = ~w_prod + 1'b1;
        end else begin
            {w_fix_hi, w_fix_lo} = w_prod;
        end
    end

    // Controller and datapath registers: accept, iterate, fix up, report.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (op[1] && (b == '0)) begin
                            // Divide by zero exits immediately; HI/LO keep the old result.
                            r_done <= 1'b1;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_is_div  <= op[1];
                            r_acc_hi  <= '0;
                            r_acc_lo  <= op[1] ? w_abs_a : w_abs_b;
                            r_opnd    <= op[1] ? w_abs_b : w_abs_a;
                            r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_rem <= w_signed & a[WIDTH-1];
                            r_cnt     <= CW'(WIDTH - 1);
                            r_busy    <= 1'b1;
                            r_state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 with a result scoreboard.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;
    int          errors;
    int          checks;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: wide arithmetic on sign- or zero-extended operands, truncating division.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t  e;
        longint sx, sy, p, q, r;
        logic [63:0] v;
        logic sgn;
        sgn = ~o[0];
        sx = sgn ? longint'({{32{x[31]}}, x}) : longint'({32'h0, x});
        sy = sgn ? longint'({{32{y[31]}}, y}) : longint'({32'h0, y});
        e.dbz = 1'b0;
        if (!o[1]) begin
            p = sx * sy;
            v = p;
            e.hi = v[63:32];
            e.lo = v[31:0];
        end else begin
            q = sx / sy;
            r = sx % sy;
            v = q;
            e.lo = v[31:0];
            v = r;
            e.hi = v[31:0];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one request, push its expected result, wait (bounded) for done.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic busy0, output bit ok);
        exp_t e;
        if (o[1] && (y == 32'h0)) begin
            e.hi = last_hi;
            e.lo = last_lo;
            e.dbz = 1'b1;
        end else begin
            e = model(o, x, y);
        end
        sb.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        busy0 = busy;
        ok = 1'b0;
        lat = 0;
        if (done) begin
            ok = 1'b1;
        end else begin
            for (int n = 1; n <= 100; n++) begin
                tick();
                if (done) begin
                    ok = 1'b1;
                    lat = n;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        tick(); tick();
        checks += 5;
        if (hi !== 32'h0)       begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'h0)       begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        reset = 1'b0;
        last_hi = '0; last_lo = '0;
        tick();
    endtask

    task automatic test_mult();
        int lat; logic b0; bit ok; exp_t e;
        issue(MD_MULT, 32'hFFFFFFFD, 32'd5, lat, b0, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL mult_timeout: no done within 100 cycles"); end
        if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        if (b0 !== 1'b1) begin errors++; $display("FAIL mult_busy_accept: got %b want 1", b0); end
        e = sb.pop_front();
        checks += 4;
        if (hi !== e.hi) begin errors++; $display("FAIL mult_hi: got %h want %h", hi, e.hi); end
        if (lo !== e.lo) begin errors++; $display("FAIL mult_lo: got %h want %h", lo, e.lo); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b want 0", busy); end
        if (div_by_zero !== e.dbz) begin errors++; $display("FAIL mult_dbz: got %b want %b", div_by_zero, e.dbz); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_fixed_cases();
        int lat; logic b0; bit ok; exp_t e;
        logic [1:0]  ops [4] = '{MD_MULTU, MD_DIV, MD_DIV, MD_DIVU};
        logic [31:0] as  [4] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100};
        logic [31:0] bs  [4] = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd7};
        logic [31:0] his [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'd2};
        logic [31:0] los [4] = '{32'h00000001, 32'hFFFFFFFD, 32'h80000000, 32'd14};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], lat, b0, ok);
            e = sb.pop_front();
            checks += 5;
            if (!ok) begin errors++; $display("FAIL fixed%0d_timeout: no done", i); end
            if (hi !== his[i]) begin errors++; $display("FAIL fixed%0d_hi: got %h want %h", i, hi, his[i]); end
            if (lo !== los[i]) begin errors++; $display("FAIL fixed%0d_lo: got %h want %h", i, lo, los[i]); end
            if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL fixed%0d_model: got %h_%h want %h_%h", i, hi, lo, e.hi, e.lo); end
            if (div_by_zero !== 1'b0) begin errors++; $display("FAIL fixed%0d_dbz: got %b want 0", i, div_by_zero); end
        end
    endtask

    task automatic test_divzero();
        int lat; logic b0; bit ok; exp_t e;
        issue(MD_DIVU, 32'd7, 32'd3, lat, b0, ok);
        e = sb.pop_front();
        checks += 2;
        if (hi !== 32'd1) begin errors++; $display("FAIL dz_prior_hi: got %h want 1", hi); end
        if (lo !== 32'd2) begin errors++; $display("FAIL dz_prior_lo: got %h want 2", lo); end
        tick();
        issue(MD_DIVU, 32'd7, 32'd0, lat, b0, ok);
        e = sb.pop_front();
        checks += 6;
        if (!ok || lat != 0) begin errors++; $display("FAIL dz_latency: got %0d (ok=%0d) want 0", lat, ok); end
        if (b0 !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b want 0", b0); end
        if (div_by_zero !== e.dbz) begin errors++; $display("FAIL dz_flag: got %b want %b", div_by_zero, e.dbz); end
        if (hi !== e.hi) begin errors++; $display("FAIL dz_hi_kept: got %h want %h", hi, e.hi); end
        if (lo !== e.lo) begin errors++; $display("FAIL dz_lo_kept: got %h want %h", lo, e.lo); end
        if (e.hi !== 32'd1 || e.lo !== 32'd2) begin errors++; $display("FAIL dz_sb: got %h_%h want 1_2", e.hi, e.lo); end
        tick();
        checks += 3;
        if (done !== 1'b0) begin errors++; $display("FAIL dz_done_pulse: got %b want 0", done); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_pulse: got %b want 0", div_by_zero); end
        if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_ignore_start();
        exp_t e; int lat; bit ok; int extra;
        e = model(MD_MULTU, 32'd6, 32'd7);
        sb.push_back(e);
        op = MD_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        op = MD_DIVU; a = 32'd100; b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0; lat = 10;
        for (int n = 0; n < 100; n++) begin
            if (done) begin ok = 1'b1; break; end
            tick();
            lat++;
        end
        e = sb.pop_front();
        last_hi = e.hi; last_lo = e.lo;
        checks += 4;
        if (!ok || lat != 33) begin errors++; $display("FAIL ign_latency: got %0d want 33", lat); end
        if (hi !== e.hi) begin errors++; $display("FAIL ign_hi: got %h want %h", hi, e.hi); end
        if (lo !== 32'd42) begin errors++; $display("FAIL ign_lo: got %h want 0000002a", lo); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ign_dbz: got %b want 0", div_by_zero); end
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int seen;
        op = MD_MULT; a = 32'h12345678; b = 32'h9ABCDEF0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_hi = '0; last_lo = '0;
        checks += 4;
        if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b0; bit ok; exp_t e;
        issue(MD_DIV, 32'd1000, 32'hFFFFFFF9, lat, b0, ok);
        e = sb.pop_front();
        checks += 2;
        if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL b2b_first: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
        issue(MD_MULT, 32'h80000000, 32'h80000000, lat, b0, ok);
        e = sb.pop_front();
        checks += 3;
        if (!ok || lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        if (hi !== 32'h40000000) begin errors++; $display("FAIL b2b_hi: got %h want 40000000", hi); end
        if (lo !== e.lo) begin errors++; $display("FAIL b2b_lo: got %h want %h", lo, e.lo); end
    endtask

    task automatic test_random();
        int lat; logic b0; bit ok; exp_t e;
        logic [1:0] o; logic [31:0] x, y;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = $urandom_range(1, 15);
            if ($urandom_range(0, 5) == 0) x = 32'h80000000;
            if (o[1] && y == 32'h0) y = 32'd1;
            issue(o, x, y, lat, b0, ok);
            e = sb.pop_front();
            checks += 2;
            if (!ok || lat != 33) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 33", i, lat); end
            if (hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h want %h_%h", i, o, x, y, hi, lo, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_hi = '0;
        last_lo = '0;
        test_reset();
        test_mult();
        test_fixed_cases();
        test_divzero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
